// File: rtl/aidan_mcnay_trial_div_sequencer_if.sv
// Handshake bundle between the trial-division sequencer, its request/response
// ports and the shared iterative divider. slave = sequencer side.
interface aidan_mcnay_trial_div_sequencer_if #(
   parameter int nbits = 32
);
   logic             req_val;
   logic             req_rdy;
   logic [nbits-1:0] req_value;

   logic             resp_val;
   logic             resp_rdy;
   logic             resp_is_prime;

   logic [nbits-1:0] div_opa;
   logic [nbits-1:0] div_opb;
   logic             div_istream_val;
   logic             div_istream_rdy;
   logic             div_ostream_val;
   logic             div_ostream_rdy;
   logic [nbits-1:0] div_rem;

   modport slave (
      input  req_val, req_value, resp_rdy, div_istream_rdy, div_ostream_val, div_rem,
      output req_rdy, resp_val, resp_is_prime, div_opa, div_opb,
             div_istream_val, div_ostream_rdy
   );

   modport master (
      output req_val, req_value, resp_rdy, div_istream_rdy, div_ostream_val, div_rem,
      input  req_rdy, resp_val, resp_is_prime, div_opa, div_opb,
             div_istream_val, div_ostream_rdy
   );
endinterface

// File: rtl/aidan_mcnay_trial_div_sequencer.sv
// Trial-division sequencer driving a shared divider; returns a prime verdict.
// Define AIDAN_MCNAY_ODD_DIVISOR_EN to skip even divisors after 2.
//
// state | meaning
// IDLE  | waiting for a candidate, req_rdy high
// CHECK | decide: trivially composite, proven prime, or try next divisor
// ISSUE | present value % divisor to the divider
// WAIT  | waiting for the divider remainder
// RESP  | verdict held until consumer takes it
module aidan_mcnay_trial_div_sequencer #(
   parameter int nbits = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   aidan_mcnay_trial_div_sequencer_if.slave   bus,
   output logic                               busy,
   output logic [nbits-1:0]                   div_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t           state_r, state_n;
   logic [nbits-1:0] value_r, value_n;
   logic [nbits-1:0] divisor_r, divisor_n;
   logic [nbits-1:0] count_r, count_n;
   logic             prime_r, prime_n;

   logic [2*nbits-1:0] divisor_sq;
   logic               sq_exceeds;
   logic [nbits-1:0]   divisor_next;

   // Double-width square so the exit test is exact for any divisor.
   assign divisor_sq = {{nbits{1'b0}}, divisor_r} * {{nbits{1'b0}}, divisor_r};
   assign sq_exceeds = divisor_sq > {{nbits{1'b0}}, value_r};

`ifdef AIDAN_MCNAY_ODD_DIVISOR_EN
   assign divisor_next = (divisor_r == nbits'(2)) ? nbits'(3) : divisor_r + nbits'(2);
`else
   assign divisor_next = divisor_r + nbits'(1);
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= IDLE;
         value_r   <= '0;
         divisor_r <= nbits'(2);
         count_r   <= '0;
         prime_r   <= 1'b0;
      end else begin
         state_r   <= state_n;
         value_r   <= value_n;
         divisor_r <= divisor_n;
         count_r   <= count_n;
         prime_r   <= prime_n;
      end
   end

   always_comb begin
      state_n   = state_r;
      value_n   = value_r;
      divisor_n = divisor_r;
      count_n   = count_r;
      prime_n   = prime_r;

      case (state_r)
         IDLE: begin
            if (bus.req_val) begin
               value_n   = bus.req_value;
               divisor_n = nbits'(2);
               count_n   = '0;
               state_n   = CHECK;
            end
         end
         CHECK: begin
            if (value_r < nbits'(2)) begin
               prime_n = 1'b0;
               state_n = RESP;
            end else if (sq_exceeds) begin
               prime_n = 1'b1;
               state_n = RESP;
            end else begin
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.div_istream_rdy) state_n = WAIT;
         end
         WAIT: begin
            if (bus.div_ostream_val) begin
               count_n = (&count_r) ? count_r : count_r + nbits'(1);
               if (bus.div_rem == '0) begin
                  prime_n = 1'b0;
                  state_n = RESP;
               end else begin
                  divisor_n = divisor_next;
                  state_n   = CHECK;
               end
            end
         end
         RESP: begin
            if (bus.resp_rdy) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.req_rdy         = (state_r == IDLE);
   assign bus.resp_val        = (state_r == RESP);
   assign bus.resp_is_prime   = prime_r;
   assign bus.div_opa         = value_r;
   assign bus.div_opb         = divisor_r;
   assign bus.div_istream_val = (state_r == ISSUE);
   assign bus.div_ostream_rdy = (state_r == WAIT);
   assign busy                = (state_r != IDLE);
   assign div_count           = count_r;

endmodule

// File: tb/tb_aidan_mcnay_trial_div_sequencer.sv
// Self-checking bench: behavioural divider model plus a verdict scoreboard.
module tb_aidan_mcnay_trial_div_sequencer;
   localparam int nbits = 32;

   logic clk = 1'b0;
   logic reset;
   logic busy;
   logic [nbits-1:0] div_count;

   always #5 clk = ~clk;

   aidan_mcnay_trial_div_sequencer_if #(.nbits(nbits)) bus ();

   aidan_mcnay_trial_div_sequencer #(.nbits(nbits)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .busy      (busy),
      .div_count (div_count)
   );

   typedef struct {
      bit          prime;
      int unsigned cnt;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // divider model state
   bit          in_hold = 0;
   bit          dv_busy = 0;
   int          dv_cnt  = 0;
   int          dv_lat  = 2;
   logic [31:0] dv_rem  = '0;

   bit fired_req, fired_resp, saw_issue;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void ref_model(input longint unsigned v, output bit prime,
                                     output int unsigned cnt);
      longint unsigned d;
      cnt   = 0;
      prime = 0;
      if (v < 2) return;
      d = 2;
      while (d * d <= v) begin
         cnt++;
         if (v % d == 0) return;
`ifdef AIDAN_MCNAY_ODD_DIVISOR_EN
         d = (d == 2) ? 3 : d + 2;
`else
         d = d + 1;
`endif
      end
      prime = 1;
   endfunction

   // One clock: note handshakes seen before the edge, then advance the divider model.
   task automatic tick();
      bit rst_now, f_req, f_in, f_out, f_resp;
      logic [31:0] a, b;
      exp_t e;
      rst_now = reset;
      f_req   = rst_now && bus.req_val && bus.req_rdy;
      f_in    = rst_now && bus.div_istream_val && bus.div_istream_rdy;
      f_out   = rst_now && bus.div_ostream_val && bus.div_ostream_rdy;
      f_resp  = rst_now && bus.resp_val && bus.resp_rdy;
      a = bus.div_opa;
      b = bus.div_opb;
      if (bus.div_istream_val) saw_issue = 1;
      if (f_req) begin
         ref_model(bus.req_value, e.prime, e.cnt);
         sb.push_back(e);
      end
      if (f_resp) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_resp", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("verdict", bus.resp_is_prime, e.prime);
            chk("div_count", div_count, e.cnt);
         end
      end
      fired_req  = f_req;
      fired_resp = f_resp;
      @(posedge clk);
      #1;
      if (!rst_now) begin
         dv_busy             = 0;
         bus.div_ostream_val = 0;
      end else begin
         if (f_out) begin
            bus.div_ostream_val = 0;
            dv_busy             = 0;
         end
         if (f_in) begin
            dv_busy = 1;
            dv_cnt  = dv_lat;
            dv_rem  = a % b;
         end else if (dv_busy && !bus.div_ostream_val) begin
            dv_cnt--;
            if (dv_cnt <= 0) begin
               bus.div_ostream_val = 1;
               bus.div_rem         = dv_rem;
            end
         end
      end
      bus.div_istream_rdy = !dv_busy && !in_hold;
   endtask

   task automatic run_cand(input logic [31:0] v, input int hold_in, input int hold_resp,
                           output int lat);
      bit          p;
      int unsigned c;
      int          g;
      ref_model(v, p, c);
      bus.req_value = v;
      bus.req_val   = 1;
      fired_req     = 0;
      for (int i = 0; i < 20 && !fired_req; i++) tick();
      if (!fired_req) chk("req_accept_timeout", 0, 1);
      bus.req_val = 0;
      lat = 1;
      if (hold_in > 0) begin
         in_hold             = 1;
         bus.div_istream_rdy = 0;
         g = 0;
         while (!bus.div_istream_val && g < 20) begin tick(); g++; lat++; end
         for (int i = 0; i < hold_in; i++) begin
            chk("hold_istream_val", bus.div_istream_val, 1);
            chk("hold_opa", bus.div_opa, v);
            chk("hold_opb", bus.div_opb, 2);
            tick();
            lat++;
         end
         in_hold             = 0;
         bus.div_istream_rdy = !dv_busy;
      end
      g = 0;
      while (!bus.resp_val && g < 5000) begin tick(); g++; lat++; end
      if (!bus.resp_val) chk("resp_timeout", 0, 1);
      for (int i = 0; i < hold_resp; i++) begin
         chk("hold_resp_val", bus.resp_val, 1);
         chk("hold_resp_prime", bus.resp_is_prime, p);
         chk("hold_req_rdy", bus.req_rdy, 0);
         bus.req_val   = i[0];
         bus.req_value = 32'd6;
         tick();
      end
      bus.req_val  = 0;
      bus.resp_rdy = 1;
      tick();
      bus.resp_rdy = 0;
      if (!fired_resp) chk("resp_fire", 0, 1);
      chk("idle_busy", busy, 0);
      chk("idle_req_rdy", bus.req_rdy, 1);
   endtask

   initial begin
      int lat;
      int g;
      reset               = 0;
      bus.req_val         = 0;
      bus.req_value       = '0;
      bus.resp_rdy        = 0;
      bus.div_istream_rdy = 1;
      bus.div_ostream_val = 0;
      bus.div_rem         = '0;
      tick();
      tick();
      chk("rst_req_rdy", bus.req_rdy, 1);
      chk("rst_resp_val", bus.resp_val, 0);
      chk("rst_prime", bus.resp_is_prime, 0);
      chk("rst_ival", bus.div_istream_val, 0);
      chk("rst_ordy", bus.div_ostream_rdy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", div_count, 0);
      reset = 1;
      tick();

      saw_issue = 0;
      run_cand(0, 0, 0, lat);
      run_cand(1, 0, 0, lat);
      chk("no_issue_0_1", saw_issue, 0);

      run_cand(2, 0, 0, lat);
      chk("latency_2", lat, 2);
      run_cand(3, 0, 0, lat);
      chk("count_3", div_count, 0);

      run_cand(91, 0, 0, lat);
`ifdef AIDAN_MCNAY_ODD_DIVISOR_EN
      chk("count_91", div_count, 4);
`else
      chk("count_91", div_count, 6);
`endif

      run_cand(97, 5, 10, lat);
`ifdef AIDAN_MCNAY_ODD_DIVISOR_EN
      chk("count_97", div_count, 5);
`else
      chk("count_97", div_count, 8);
`endif

      // abort in WAIT after a few transactions
      dv_lat        = 4;
      bus.req_value = 97;
      bus.req_val   = 1;
      fired_req     = 0;
      for (int i = 0; i < 20 && !fired_req; i++) tick();
      bus.req_val = 0;
      g = 0;
      while (!(bus.div_ostream_rdy && div_count >= 3) && g < 200) begin tick(); g++; end
      chk("reached_wait", bus.div_ostream_rdy, 1);
      reset = 0;
      tick();
      chk("abort_req_rdy", bus.req_rdy, 1);
      chk("abort_resp_val", bus.resp_val, 0);
      chk("abort_count", div_count, 0);
      chk("abort_busy", busy, 0);
      reset = 1;
      sb.delete();
      tick();
      dv_lat = 2;
      run_cand(4, 0, 0, lat);
      chk("count_4", div_count, 1);

      for (int v = 0; v < 40; v++) begin
         dv_lat = int'($urandom_range(1, 3));
         run_cand(v, 0, 0, lat);
      end
      for (int i = 0; i < 15; i++) begin
         dv_lat = int'($urandom_range(1, 4));
         run_cand($urandom_range(0, 3000), 0, 0, lat);
      end
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/aidan_mcnay_trial_div_sequencer.md
Name: aidan_mcnay_trial_div_sequencer

Overview:
Sequences a shared iterative divider to run trial division on one latched candidate value. Accepts a candidate over a val/rdy request port and issues divisions value % d for d = 2, 3, 4, … until a zero remainder is found or d*d > value. Returns a single prime/not-prime verdict over a val/rdy response port. Sits between the serial-input front end and the divider, and replaces ad-hoc counter and latch sequencing.

Parameters:
nbits, 32, width of the candidate, divisor and remainder

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-low reset (reset==0 at posedge clears state)
req_val  input  1  candidate valid
req_rdy  output  1  sequencer can accept a candidate
req_value  input  nbits  candidate value
resp_val  output  1  verdict valid
resp_rdy  input  1  consumer accepts verdict
resp_is_prime  output  1  1 = candidate is prime
div_opa  output  nbits  dividend, the latched candidate
div_opb  output  nbits  current trial divisor
div_istream_val  output  1  divider operand valid
div_istream_rdy  input  1  divider can accept operands
div_ostream_val  input  1  divider result valid
div_ostream_rdy  output  1  sequencer accepts result
div_rem  input  nbits  remainder from the divider
busy  output  1  high in any state other than IDLE
div_count  output  nbits  number of divider transactions completed for the current or last candidate

Behaviour:
- Reset values: state=IDLE; req_rdy=1; resp_val=0; resp_is_prime=0; div_istream_val=0; div_ostream_rdy=0; busy=0; div_count=0; divisor=2; value=0.
- Reset has priority over all other events. Reset asserted mid-operation aborts immediately. Any divider transaction in flight is abandoned; the divider shares this reset.
- States: IDLE, CHECK, ISSUE, WAIT, RESP. Outputs are Moore (decoded from state only).
- IDLE:
  - req_rdy=1.
  - On req_val&&req_rdy: latch req_value, set divisor=2, clear div_count, go to CHECK.
- CHECK (one cycle, no handshakes):
  - value<2: resp_is_prime<=0, go to RESP.
  - Else if divisor*divisor > value: resp_is_prime<=1, go to RESP. The product is computed at 2*nbits width, so it never overflows.
  - Else go to ISSUE.
- ISSUE:
  - div_istream_val=1, with div_opa=value and div_opb=divisor.
  - On div_istream_rdy, go to WAIT.
  - div_opa/div_opb are stable while div_istream_val=1.
- WAIT:
  - div_ostream_rdy=1.
  - On div_ostream_val: div_count<=div_count+1.
  - If div_rem==0: resp_is_prime<=0, go to RESP.
  - Else divisor<=divisor+1 (or the step defined under Optional Feature), go to CHECK.
- RESP:
  - resp_val=1; resp_is_prime is held stable.
  - On resp_rdy, go to IDLE.
  - req_rdy=0, so a new request cannot overlap a held response.
- Latency: the minimum is 2 cycles from the accepting edge to resp_val=1 (CHECK, then RESP). The divider latency adds per trial.
- Simultaneous events:
  - req_val asserted while not in IDLE is ignored and not queued.
  - resp_rdy asserted outside RESP is ignored.
- Divisor never wraps: the loop exits once divisor exceeds sqrt(value) < 2^(nbits/2)+1.
- div_count saturates at all-ones; it cannot saturate in practice.

Optional Feature:
Macro AIDAN_MCNAY_ODD_DIVISOR_EN.
- Defined: after divisor 2 the step is +2 (trial sequence 2, 3, 5, 7, 9, …). Roughly halves the number of divider transactions.
- Undefined: the step is always +1 (trial sequence 2, 3, 4, 5, …).
- The verdict is identical in both builds; only div_count and latency differ.

Test Plan:
- req_value=0, then req_value=1 -> resp_is_prime=0 for each, div_count=0, div_istream_val never asserted.
- req_value=2 -> resp_is_prime=0→1, resp_val high exactly 2 cycles after the accepting edge, div_count=0. Then req_value=3 -> prime, div_count=0.
- req_value=91 (7*13) -> resp_is_prime=0; div_count=6 (divisors 2..7), or 4 with the macro (2, 3, 5, 7).
- req_value=97 -> resp_is_prime=1; div_count=8 (divisors 2..9), or 5 with the macro (2, 3, 5, 7, 9).
- Backpressure: hold div_istream_rdy=0 for 5 cycles -> div_opa/div_opb stable. Hold resp_rdy=0 for 10 cycles -> resp_val and resp_is_prime stable, req_rdy=0, req_val pulses ignored.
- Assert reset=0 during WAIT for value 97 -> next cycle state=IDLE, req_rdy=1, resp_val=0, div_count=0. A following req_value=4 -> not prime, div_count=1.
